// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory, with optional load forwarding.
// Define STORE_BUF_FWD_EN to forward buffered data; otherwise loads stall until the buffer drains.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_stall,
  input  logic                     mem_grant,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic push_s;
  logic drain_s;

`ifdef STORE_BUF_FWD_EN
  // Byte offsets are ignored: a store hits any load to the same word.
  function automatic logic word_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    word_match = (a[ADDR_W-1:2] == b[ADDR_W-1:2]);
  endfunction

  logic unused_ld_offset_s;
  assign unused_ld_offset_s = &{1'b0, ld_addr[1:0]};
`else
  logic unused_ld_addr_s;
  assign unused_ld_addr_s = &{1'b0, ld_addr};
`endif

  // Handshake decode: a full buffer rejects pushes even if it drains this cycle.
  always_comb begin
    push_s  = 1'b0;
    drain_s = 1'b0;
    if (count_r < FULL_CNT) begin
      push_s = st_valid;
    end else begin
      push_s = 1'b0;
    end
    if (count_r != {CNT_W{1'b0}}) begin
      drain_s = mem_grant;
    end else begin
      drain_s = 1'b0;
    end
  end

  // Pointers and occupancy; reset discards everything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (drain_s) begin
        head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {ADDR_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        addr_r[tail_r] <= st_addr;
        data_r[tail_r] <= st_data;
      end
    end
  end

  // Store-side and drain-side outputs.
  always_comb begin
    st_ready  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    count     = count_r;
    st_ready  = (count_r < FULL_CNT);
    mem_write = drain_s;
    if (count_r != {CNT_W{1'b0}}) begin
      mem_addr  = addr_r[head_r];
      mem_wdata = data_r[head_r];
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Load lookup. Walking oldest to youngest lets the youngest match win;
  // the head entry draining this cycle is still valid here.
  always_comb begin
    ld_hit   = 1'b0;
    ld_data  = {DATA_W{1'b0}};
    ld_stall = 1'b0;
`ifdef STORE_BUF_FWD_EN
    if (ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count_r) &&
            word_match(addr_r[head_r + PTR_W'(i)], ld_addr)) begin
          ld_hit  = 1'b1;
          ld_data = data_r[head_r + PTR_W'(i)];
        end else begin
          ld_hit  = ld_hit;
          ld_data = ld_data;
        end
      end
    end else begin
      ld_hit  = 1'b0;
      ld_data = {DATA_W{1'b0}};
    end
`else
    if (ld_valid && (count_r != {CNT_W{1'b0}})) begin
      ld_stall = 1'b1;
    end else begin
      ld_stall = 1'b0;
    end
`endif
  end

endmodule
